tokenizer: RTL and testbench
============================

TOKENIZER -- requirements
Module: tokenizer

Interface
REQ-001 The module SHALL have parameter ASZ, default 17, giving the byte-address width.
REQ-002 The module SHALL have parameter LSZ, default 8, giving the token-length width.
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port start, input, 1 bit: begin a scan at sa; honoured only in IDLE.
REQ-007 Port sa, input, ASZ bits: scan start address, sampled with start.
REQ-008 Port ch, input, 8 bits: memory byte for the ai value of the previous cycle (1-cycle read latency).
REQ-009 Port ai, output, ASZ bits: memory read address.
REQ-010 Port bsy, output, 1 bit: scan in progress.
REQ-011 Port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-012 Port tok, output, ASZ bits: address of the first token byte.
REQ-013 Port len, output, LSZ bits: token length in bytes.
REQ-014 Port nxt, output, ASZ bits: address of the terminating byte, used as sa for the next scan.
REQ-015 Port eol, output, 1 bit: NUL reached before any token byte.
REQ-016 Port err, output, 1 bit: token exceeded 2^LSZ-1 bytes.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, SKIP, SCAN and DONE.
REQ-018 IDLE: on start, latch ai<=sa, clear len/eol/err, go to FETCH, and assert bsy from the next cycle.
REQ-019 FETCH: ai<=ai+1 and go to SKIP, since ch is not yet valid.
REQ-020 SKIP: on delimiter (0x20) ch, ai<=ai+1 and stay; on ch==0x00, set eol, nxt, len=0, and go to DONE; otherwise set tok to the byte address, len<=1, ai<=ai+1, and go to SCAN.
REQ-021 SCAN: on a non-delimiter, non-NUL ch, len<=len+1 and ai<=ai+1; on a delimiter or NUL, set nxt to that byte's address and go to DONE, with eol left 0.
REQ-022 In SCAN, if len==2^LSZ-1 and ch is not a terminator, the FSM SHALL set err, set nxt to that byte's address, hold len, and go to DONE.
REQ-023 DONE: assert done for exactly one cycle, drop bsy, and return to IDLE.
REQ-024 Latency SHALL be done asserted exactly 3+S+L cycles after the start cycle (S = skipped delimiters, L = len); minimum 3.
REQ-025 tok, len, nxt, eol and err SHALL hold their values from DONE until the next accepted start or reset.
REQ-026 The address SHALL wrap modulo 2^ASZ without a flag.
REQ-027 start asserted while bsy SHALL be ignored.
REQ-028 start asserted in the DONE cycle SHALL be ignored; a new scan is accepted from IDLE only.

Reset
REQ-029 When rst is asserted, the FSM SHALL go to IDLE and all outputs SHALL be 0 on the next edge.
REQ-030 rst SHALL take priority over start and abort any scan with no done pulse.

Configuration
REQ-031 When TOKENIZER_TAB_EN is defined, 0x09 SHALL be a delimiter in addition to 0x20 in both SKIP and SCAN.
REQ-032 When TOKENIZER_TAB_EN is not defined, 0x09 SHALL be an ordinary token byte.

Structure
REQ-033 Shared package forthsuper_pkg SHALL hold the enum tok_sts (IDLE, FETCH, SKIP, SCAN, DONE) and constants CH_NUL=0x00, CH_SP=0x20, CH_TAB=0x09.
REQ-034 The delimiter/terminator classification SHALL be a combinational sub-module tok_delim (inputs ch; outputs dlm, nul), which contains the TOKENIZER_TAB_EN switch.
REQ-035 tokenizer SHALL be the only sequential logic.

Verification
REQ-036 Memory "  12 ab\0" at 0x100, start with sa=0x100 -> done at cycle 7, tok=0x102, len=2, nxt=0x104, eol=0, err=0.
REQ-037 Rescan with sa=0x104 on the same memory -> done at cycle 6, tok=0x105, len=2, nxt=0x107; rescan with sa=0x107 -> done at cycle 3, eol=1, len=0.
REQ-038 Memory "\tDUP\0" at 0 -> with TOKENIZER_TAB_EN: tok=1, len=3; without it: tok=0, len=4.
REQ-039 LSZ=4 with 20 non-delimiter bytes -> err=1, len=15, nxt=sa+15.
REQ-040 rst asserted in SCAN cycle 4 -> no done pulse, all outputs 0, then a new start completes normally.
REQ-041 start pulsed every cycle during a scan -> exactly one done pulse, with results of the first sa.

Source files
------------

// File: rtl/tokenizer_pkg.sv
// Shared types and character constants for the tokenizer slice.
package forthsuper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SKIP,
    SCAN,
    DONE
  } tok_sts;

  localparam logic [7:0] CH_NUL = 8'h00;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;

endpackage

// File: rtl/tokenizer_if.sv
// Scan request / memory / result bundle between a requester and the tokenizer.
interface tokenizer_if #(
  parameter int ASZ = 17,
  parameter int LSZ = 8
);
  logic           start;
  logic [ASZ-1:0] sa;
  logic [7:0]     ch;
  logic [ASZ-1:0] ai;
  logic           bsy;
  logic           done;
  logic [ASZ-1:0] tok;
  logic [LSZ-1:0] len;
  logic [ASZ-1:0] nxt;
  logic           eol;
  logic           err;

  modport master (
    output start, sa, ch,
    input  ai, bsy, done, tok, len, nxt, eol, err
  );

  modport slave (
    input  start, sa, ch,
    output ai, bsy, done, tok, len, nxt, eol, err
  );
endinterface

// File: rtl/tokenizer_delim.sv
// Byte classifier: delimiter and NUL detection.
// Build option: define TOKENIZER_TAB_EN to treat 0x09 as a delimiter too.
module tok_delim
  import forthsuper_pkg::*;
(
  input  logic [7:0] ch,
  output logic       dlm,
  output logic       nul
);

  // Classify the current memory byte.
  always_comb begin
`ifdef TOKENIZER_TAB_EN
    dlm = (ch == CH_SP) || (ch == CH_TAB);
`else
    dlm = (ch == CH_SP);
`endif
    nul = (ch == CH_NUL);
  end

endmodule

// File: rtl/tokenizer.sv
// Whitespace tokenizer: skips delimiters from a start address, then measures
// the following token in a byte memory with one cycle of read latency.
// Build option: TOKENIZER_TAB_EN (handled inside tok_delim).
module tokenizer
  import forthsuper_pkg::*;
#(
  parameter int ASZ = 17,
  parameter int LSZ = 8
) (
  input logic        clk,
  input logic        rst,
  tokenizer_if.slave bus
);

  localparam logic [LSZ-1:0] LEN_MAX = '1;
  localparam logic [LSZ-1:0] LEN_ONE = LSZ'(1);
  localparam logic [ASZ-1:0] ADR_ONE = ASZ'(1);

  tok_sts         state_q, state_d;
  logic [ASZ-1:0] ai_q, ai_d;
  logic [ASZ-1:0] tok_q, tok_d;
  logic [LSZ-1:0] len_q, len_d;
  logic [ASZ-1:0] nxt_q, nxt_d;
  logic           eol_q, eol_d;
  logic           err_q, err_d;

  logic           dlm;
  logic           nul;
  logic [ASZ-1:0] ch_addr;

  tok_delim u_delim (
    .ch  (bus.ch),
    .dlm (dlm),
    .nul (nul)
  );

  // ch always reflects the address issued one cycle earlier.
  assign ch_addr = ai_q - ADR_ONE;

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ai_q    <= '0;
      tok_q   <= '0;
      len_q   <= '0;
      nxt_q   <= '0;
      eol_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ai_q    <= ai_d;
      tok_q   <= tok_d;
      len_q   <= len_d;
      nxt_q   <= nxt_d;
      eol_q   <= eol_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    ai_d    = ai_q;
    tok_d   = tok_q;
    len_d   = len_q;
    nxt_d   = nxt_q;
    eol_d   = eol_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ai_d    = bus.sa;
          len_d   = '0;
          eol_d   = 1'b0;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        ai_d    = ai_q + ADR_ONE;
        state_d = SKIP;
      end
      SKIP: begin
        if (dlm) begin
          ai_d = ai_q + ADR_ONE;
        end else if (nul) begin
          eol_d   = 1'b1;
          nxt_d   = ch_addr;
          len_d   = '0;
          state_d = DONE;
        end else begin
          tok_d   = ch_addr;
          len_d   = LEN_ONE;
          ai_d    = ai_q + ADR_ONE;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (dlm || nul) begin
          nxt_d   = ch_addr;
          state_d = DONE;
        end else if (len_q == LEN_MAX) begin
          err_d   = 1'b1;
          nxt_d   = ch_addr;
          state_d = DONE;
        end else begin
          len_d = len_q + LEN_ONE;
          ai_d  = ai_q + ADR_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status decode and result outputs.
  always_comb begin
    bus.bsy  = (state_q == FETCH) || (state_q == SKIP) || (state_q == SCAN);
    bus.done = (state_q == DONE);
    bus.ai   = ai_q;
    bus.tok  = tok_q;
    bus.len  = len_q;
    bus.nxt  = nxt_q;
    bus.eol  = eol_q;
    bus.err  = err_q;
  end

endmodule

// File: tb/tb_tokenizer.sv
// Self-checking bench for tokenizer: default DUT (LSZ=8) and a short-length
// DUT (LSZ=4) share one byte memory; a behavioural scan model predicts results.
module tb_tokenizer;

  localparam int ASZ = 17;
  localparam int MSZ = 1 << ASZ;

  typedef struct {
    logic [ASZ-1:0] tok;
    int             len;
    logic [ASZ-1:0] nxt;
    logic           eol;
    logic           err;
    int             lat;
  } exp_t;

  logic clk;
  logic rst;
  logic [7:0] mem [0:MSZ-1];
  logic [ASZ-1:0] prev_tok [2];
  int asserts;
  int errors;

  tokenizer_if #(.ASZ(ASZ), .LSZ(8)) b0 ();
  tokenizer_if #(.ASZ(ASZ), .LSZ(4)) b1 ();

  tokenizer #(.ASZ(ASZ), .LSZ(8)) dut (.clk(clk), .rst(rst), .bus(b0));
  tokenizer #(.ASZ(ASZ), .LSZ(4)) dut_s (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory with one cycle read latency for each DUT.
  always @(posedge clk) begin
    b0.ch <= mem[b0.ai];
    b1.ch <= mem[b1.ai];
  end

  function automatic bit is_dlm(input logic [7:0] c);
`ifdef TOKENIZER_TAB_EN
    return (c == 8'h20) || (c == 8'h09);
`else
    return (c == 8'h20);
`endif
  endfunction

  function automatic exp_t model(input int sel, input logic [ASZ-1:0] sa);
    exp_t e;
    logic [ASZ-1:0] a;
    int s;
    int lmax;
    lmax = (sel != 0) ? 15 : 255;
    e.tok = prev_tok[sel]; e.len = 0; e.nxt = '0; e.eol = 0; e.err = 0; e.lat = 0;
    a = sa;
    s = 0;
    while (is_dlm(mem[a]) && s < MSZ) begin
      a = a + 1'b1;
      s++;
    end
    if (mem[a] == 8'h00) begin
      e.eol = 1'b1;
      e.nxt = a;
      e.lat = 3 + s;
      return e;
    end
    e.tok = a;
    e.len = 1;
    a = a + 1'b1;
    while (1) begin
      if (is_dlm(mem[a]) || mem[a] == 8'h00) begin
        e.nxt = a;
        break;
      end else if (e.len == lmax) begin
        e.err = 1'b1;
        e.nxt = a;
        break;
      end
      e.len++;
      a = a + 1'b1;
    end
    e.lat = 3 + s + e.len;
    return e;
  endfunction

  task automatic put_str(input logic [ASZ-1:0] addr, input string s);
    logic [ASZ-1:0] a;
    a = addr;
    for (int i = 0; i < s.len(); i++) begin
      mem[a] = s[i];
      a = a + 1'b1;
    end
    mem[a] = 8'h00;
  endtask

  task automatic drive(input int sel, input logic st, input logic [ASZ-1:0] a);
    if (sel != 0) begin
      b1.start = st; b1.sa = a;
    end else begin
      b0.start = st; b0.sa = a;
    end
  endtask

  task automatic read_out(input int sel, output logic [ASZ-1:0] ai, output logic bsy,
                          output logic done, output logic [ASZ-1:0] tok, output int len,
                          output logic [ASZ-1:0] nxt, output logic eol, output logic err);
    if (sel != 0) begin
      ai = b1.ai; bsy = b1.bsy; done = b1.done; tok = b1.tok;
      len = int'(b1.len); nxt = b1.nxt; eol = b1.eol; err = b1.err;
    end else begin
      ai = b0.ai; bsy = b0.bsy; done = b0.done; tok = b0.tok;
      len = int'(b0.len); nxt = b0.nxt; eol = b0.eol; err = b0.err;
    end
  endtask

  task automatic check_zero(input int sel, input string name);
    logic [ASZ-1:0] ai, tok, nxt;
    logic bsy, done, eol, err;
    int len;
    read_out(sel, ai, bsy, done, tok, len, nxt, eol, err);
    asserts++;
    if ({ai, bsy, done, tok, nxt, eol, err} !== '0 || len !== 0) begin
      errors++;
      $display("FAIL %s dut%0d: ai=%h bsy=%b done=%b tok=%h len=%0d nxt=%h eol=%b err=%b, required all 0",
               name, sel, ai, bsy, done, tok, len, nxt, eol, err);
    end
  endtask

  // One full scan; spam keeps start high with random sa throughout and into DONE.
  task automatic do_scan(input int sel, input logic [ASZ-1:0] sa, input bit spam, input string name);
    exp_t e;
    logic [ASZ-1:0] ai, tok, nxt;
    logic bsy, done, eol, err;
    int len, n;
    bit got, bsy_bad;
    e = model(sel, sa);
    @(negedge clk);
    drive(sel, 1'b1, sa);
    n = 0; got = 0; bsy_bad = 0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      read_out(sel, ai, bsy, done, tok, len, nxt, eol, err);
      if (done === 1'b1) got = 1;
      else if (bsy !== 1'b1) bsy_bad = 1;
      if (spam) drive(sel, 1'b1, ASZ'($urandom));
      else drive(sel, 1'b0, '0);
    end
    asserts++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles, required at %0d", name, n, e.lat);
      drive(sel, 1'b0, '0);
      return;
    end
    asserts++;
    if (n !== e.lat) begin errors++; $display("FAIL %s latency: got %0d required %0d", name, n, e.lat); end
    asserts++;
    if (bsy_bad) begin errors++; $display("FAIL %s bsy: got 0 during scan required 1", name); end
    asserts++;
    if (bsy !== 1'b0) begin errors++; $display("FAIL %s bsy_done: got %b required 0", name, bsy); end
    asserts++;
    if (tok !== e.tok) begin errors++; $display("FAIL %s tok: got %h required %h", name, tok, e.tok); end
    asserts++;
    if (len !== e.len) begin errors++; $display("FAIL %s len: got %0d required %0d", name, len, e.len); end
    asserts++;
    if (nxt !== e.nxt) begin errors++; $display("FAIL %s nxt: got %h required %h", name, nxt, e.nxt); end
    asserts++;
    if (eol !== e.eol || err !== e.err) begin
      errors++;
      $display("FAIL %s flags: got eol=%b err=%b required eol=%b err=%b", name, eol, err, e.eol, e.err);
    end
    prev_tok[sel] = e.tok;
    // Cycle after DONE: single pulse, still idle even if start was high in DONE.
    @(negedge clk);
    read_out(sel, ai, bsy, done, tok, len, nxt, eol, err);
    drive(sel, 1'b0, '0);
    asserts++;
    if (done !== 1'b0 || bsy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b bsy=%b required 0 0", name, done, bsy);
    end
    asserts++;
    if (tok !== e.tok || len !== e.len || nxt !== e.nxt || eol !== e.eol || err !== e.err) begin
      errors++;
      $display("FAIL %s hold: got tok=%h len=%0d nxt=%h required tok=%h len=%0d nxt=%h",
               name, tok, len, nxt, e.tok, e.len, e.nxt);
    end
    @(negedge clk);
    read_out(sel, ai, bsy, done, tok, len, nxt, eol, err);
    asserts++;
    if (bsy !== 1'b0) begin errors++; $display("FAIL %s idle: got bsy=%b required 0", name, bsy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst = 1'b0;
    prev_tok[0] = '0;
    prev_tok[1] = '0;
  endtask

  task automatic test_example();
    put_str(17'h100, "  12 ab");
    do_scan(0, 17'h100, 0, "ex_first");
    do_scan(0, 17'h104, 0, "ex_second");
    do_scan(0, 17'h107, 0, "ex_eol");
  endtask

  task automatic test_tab();
    put_str(17'h0, "\tDUP");
    do_scan(0, 17'h0, 0, "tab");
  endtask

  task automatic test_wrap();
    mem[17'h1FFFE] = 8'h20;
    mem[17'h1FFFF] = 8'h78;
    mem[17'h00000] = 8'h79;
    mem[17'h00001] = 8'h7A;
    mem[17'h00002] = 8'h00;
    do_scan(0, 17'h1FFFE, 0, "wrap");
  endtask

  task automatic test_err();
    put_str(17'h300, "xxxxxxxxxxxxxxxxxxxx");
    do_scan(1, 17'h300, 0, "err_lsz4");
    do_scan(0, 17'h300, 0, "noerr_lsz8");
  endtask

  task automatic test_reset_abort();
    logic [ASZ-1:0] ai, tok, nxt;
    logic bsy, done, eol, err;
    int len;
    bit saw_done;
    put_str(17'h200, "abcdefghij ");
    saw_done = 0;
    @(negedge clk);
    drive(0, 1'b1, 17'h200);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      drive(0, 1'b0, '0);
      read_out(0, ai, bsy, done, tok, len, nxt, eol, err);
      if (done === 1'b1) saw_done = 1;
    end
    rst = 1'b1;
    @(negedge clk);
    check_zero(0, "abort_reset");
    rst = 1'b0;
    prev_tok[0] = '0;
    prev_tok[1] = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      read_out(0, ai, bsy, done, tok, len, nxt, eol, err);
      if (done === 1'b1) saw_done = 1;
    end
    asserts++;
    if (saw_done) begin errors++; $display("FAIL abort_no_done: got done pulse required none"); end
    do_scan(0, 17'h200, 0, "after_abort");
  endtask

  task automatic test_back_to_back();
    put_str(17'h400, "   spam  more");
    do_scan(0, 17'h400, 1, "spam_start");
    do_scan(1, 17'h400, 1, "spam_start_s");
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) mem[17'h1000 + i] = 8'h20;
      else if (r < 40) mem[17'h1000 + i] = 8'h09;
      else if (r < 43) mem[17'h1000 + i] = 8'h00;
      else mem[17'h1000 + i] = 8'h61 + 8'($urandom_range(0, 25));
    end
    mem[17'h1100] = 8'h00;
    for (int i = 0; i < 30; i++) begin
      do_scan(i % 2, 17'h1000 + 17'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    asserts = 0;
    errors = 0;
    rst = 1'b1;
    b0.start = 1'b0; b0.sa = '0;
    b1.start = 1'b0; b1.sa = '0;
    for (int i = 0; i < MSZ; i++) mem[i] = 8'h00;
    test_reset();
    test_example();
    test_tab();
    test_wrap();
    test_err();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule
